// File: rtl/fpu_pkg.sv
// Shared FPU types: bf16 field layout, flag bundle, add/sub state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fpu_pkg;

  localparam int BF16_EXP_W = 8;
  localparam int BF16_MAN_W = 7;
  localparam int BF16_BIAS  = 127;

  localparam logic [15:0] BF16_QNAN = 16'h7FC0;
  localparam logic [15:0] BF16_PINF = 16'h7F80;
  localparam logic [15:0] BF16_NINF = 16'hFF80;

  typedef struct packed {
    logic                  sign;
    logic [BF16_EXP_W-1:0] exp;
    logic [BF16_MAN_W-1:0] man;
  } bf16_t;

  typedef struct packed {
    logic nv;
    logic of;
    logic uf;
    logic nx;
  } fpu_flags_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_ADD,
    ST_NORM,
    ST_ROUND,
    ST_DONE
  } addsub_state_e;

endpackage

// File: rtl/bf16_round_rne.sv
// Round-to-nearest-even of a normalised 11-bit significand {1,frac[6:0],G,R,S}, with range checks.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module bf16_round_rne
  import fpu_pkg::*;
(
  input  logic              i_sign,
  input  logic signed [9:0] i_exp,
  input  logic [10:0]       i_sig,
  output bf16_t             o_res,
  output logic              o_of,
  output logic              o_uf,
  output logic              o_nx
);

  logic              w_round_up;
  logic [8:0]        w_mant9;
  logic signed [9:0] w_exp_adj;
  logic [6:0]        w_frac;
  logic              w_inexact;

  // Rounding increment, carry renormalisation, then overflow/underflow/zero selection.
  always_comb begin
    w_round_up = i_sig[2] & (i_sig[1] | i_sig[0] | i_sig[3]);
    w_mant9    = {1'b0, i_sig[10:3]} + {8'b0, w_round_up};
    w_exp_adj  = w_mant9[8] ? (i_exp + 10'sd1) : i_exp;
    w_frac     = w_mant9[8] ? w_mant9[7:1] : w_mant9[6:0];
    w_inexact  = |i_sig[2:0];
    o_res      = '0;
    o_of       = 1'b0;
    o_uf       = 1'b0;
    o_nx       = 1'b0;
    if (i_sig == 11'd0) begin
      o_res = {i_sign, 15'h0000};
    end else if (w_exp_adj >= 10'sd255) begin
      o_res = {i_sign, BF16_PINF[14:0]};
      o_of  = 1'b1;
      o_nx  = 1'b1;
    end else if (w_exp_adj <= 10'sd0) begin
      o_res = {i_sign, 15'h0000};
      o_uf  = 1'b1;
      o_nx  = 1'b1;
    end else begin
      o_res = {i_sign, w_exp_adj[7:0], w_frac};
      o_nx  = w_inexact;
    end
  end

endmodule

// File: rtl/bf16_addsub.sv
// Multi-cycle bf16 add/subtract, one operation in flight, denormals flushed to zero.
// Latency: 4+k cycles accept-to-valid_o (k = normalise left shifts), 1 cycle for NaN/Inf bypass.
// Backpressure: ready_o only in IDLE; result held in DONE until ready_i.
module bf16_addsub
  import fpu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic                   op_i,
  input  logic [EXP_W+MAN_W:0]   a_i,
  input  logic [EXP_W+MAN_W:0]   b_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [EXP_W+MAN_W:0]   result_o,
  output logic [3:0]             flags_o
);

  addsub_state_e     r_state, w_next;
  bf16_t             r_a, r_b, r_result;
  fpu_flags_t        r_flags;
  logic              r_op, r_sign, r_eff_sub, r_both_zero;
  logic signed [9:0] r_exp;
  logic [10:0]       r_big, r_small;
  logic [11:0]       r_sum;

  logic        w_b_sign, w_a_zero, w_b_zero, w_a_nan, w_b_nan, w_a_inf, w_b_inf;
  logic        w_special, w_spec_nv, w_swap, w_big_sign;
  logic [15:0] w_spec_res;
  logic [14:0] w_a_mag, w_b_mag;
  logic [7:0]  w_big_exp, w_sml_exp, w_diff;
  logic [10:0] w_big_sig, w_sml_sig, w_aligned;
  logic [11:0] w_sum;
  bf16_t       w_rnd_res;
  logic        w_rnd_of, w_rnd_uf, w_rnd_nx;

  // Unpack, classify specials, order by magnitude and align the smaller operand.
  always_comb begin
    w_b_sign  = r_b.sign ^ r_op;
    w_a_zero  = (r_a.exp == 8'd0);
    w_b_zero  = (r_b.exp == 8'd0);
    w_a_nan   = (&r_a.exp) & (|r_a.man);
    w_b_nan   = (&r_b.exp) & (|r_b.man);
    w_a_inf   = (&r_a.exp) & ~(|r_a.man);
    w_b_inf   = (&r_b.exp) & ~(|r_b.man);
    w_special = w_a_nan | w_b_nan | w_a_inf | w_b_inf;
    w_spec_nv = 1'b0;
    if (w_a_nan || w_b_nan) begin
      w_spec_res = BF16_QNAN;
    end else if (w_a_inf && w_b_inf) begin
      w_spec_nv  = (r_a.sign != w_b_sign);
      w_spec_res = w_spec_nv ? BF16_QNAN : (r_a.sign ? BF16_NINF : BF16_PINF);
    end else if (w_a_inf) begin
      w_spec_res = r_a.sign ? BF16_NINF : BF16_PINF;
    end else begin
      w_spec_res = w_b_sign ? BF16_NINF : BF16_PINF;
    end
    w_a_mag    = w_a_zero ? 15'd0 : {r_a.exp, r_a.man};
    w_b_mag    = w_b_zero ? 15'd0 : {r_b.exp, r_b.man};
    w_swap     = (w_b_mag > w_a_mag);
    w_big_sign = w_swap ? w_b_sign : r_a.sign;
    w_big_exp  = w_swap ? r_b.exp : r_a.exp;
    w_sml_exp  = w_swap ? r_a.exp : r_b.exp;
    w_big_sig  = w_swap ? (w_b_zero ? 11'd0 : {1'b1, r_b.man, 3'b000})
                        : (w_a_zero ? 11'd0 : {1'b1, r_a.man, 3'b000});
    w_sml_sig  = w_swap ? (w_a_zero ? 11'd0 : {1'b1, r_a.man, 3'b000})
                        : (w_b_zero ? 11'd0 : {1'b1, r_b.man, 3'b000});
    w_diff     = w_big_exp - w_sml_exp;
    if (w_diff >= 8'd11) begin
      w_aligned = {10'd0, |w_sml_sig};
    end else begin
      w_aligned = (w_sml_sig >> w_diff) | {10'd0, |(w_sml_sig & ~(11'h7FF << w_diff))};
    end
    w_sum = r_eff_sub ? ({1'b0, r_big} - {1'b0, r_small}) : ({1'b0, r_big} + {1'b0, r_small});
  end

  bf16_round_rne u_round (
    .i_sign (r_sign),
    .i_exp  (r_exp),
    .i_sig  (r_sum[10:0]),
    .o_res  (w_rnd_res),
    .o_of   (w_rnd_of),
    .o_uf   (w_rnd_uf),
    .o_nx   (w_rnd_nx)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state: specials short-circuit ALIGN straight to DONE; NORM loops once per left shift.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (valid_i) w_next = ST_ALIGN;
      ST_ALIGN: w_next = w_special ? ST_DONE : ST_ADD;
      ST_ADD:   w_next = ST_NORM;
      ST_NORM:  if (r_sum[11] || r_sum[10] || (r_sum == 12'd0)) w_next = ST_ROUND;
      ST_ROUND: w_next = ST_DONE;
      ST_DONE:  if (ready_i) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Outputs: handshake from state, result/flags straight from their registers.
  always_comb begin
    ready_o  = (r_state == ST_IDLE);
    valid_o  = (r_state == ST_DONE);
    result_o = r_result;
    flags_o  = r_flags;
  end

  // Datapath registers advanced per state; result and flags cleared when the consumer takes them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= 1'b0;
      r_sign      <= 1'b0;
      r_eff_sub   <= 1'b0;
      r_both_zero <= 1'b0;
      r_exp       <= '0;
      r_big       <= '0;
      r_small     <= '0;
      r_sum       <= '0;
      r_result    <= '0;
      r_flags     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (valid_i) begin
            r_a  <= a_i;
            r_b  <= b_i;
            r_op <= op_i;
          end
        end
        ST_ALIGN: begin
          if (w_special) begin
            r_result <= w_spec_res;
            r_flags  <= '{nv: w_spec_nv, of: 1'b0, uf: 1'b0, nx: 1'b0};
          end else begin
            r_big       <= w_big_sig;
            r_small     <= w_aligned;
            r_exp       <= {2'b00, w_big_exp};
            r_eff_sub   <= r_a.sign ^ w_b_sign;
            r_both_zero <= w_a_zero & w_b_zero;
            r_sign      <= (w_a_zero & w_b_zero) ? (r_a.sign & w_b_sign) : w_big_sign;
          end
        end
        ST_ADD: begin
          r_sum <= w_sum;
          if ((w_sum == 12'd0) && !r_both_zero) r_sign <= 1'b0;
        end
        ST_NORM: begin
          if (r_sum[11]) begin
            r_sum <= {1'b0, r_sum[11:2], r_sum[1] | r_sum[0]};
            r_exp <= r_exp + 10'sd1;
          end else if (!r_sum[10] && (r_sum != 12'd0)) begin
            r_sum <= r_sum << 1;
            r_exp <= r_exp - 10'sd1;
          end
        end
        ST_ROUND: begin
          r_result <= w_rnd_res;
          r_flags  <= '{nv: 1'b0, of: w_rnd_of, uf: w_rnd_uf, nx: w_rnd_nx};
        end
        ST_DONE: begin
          if (ready_i) begin
            r_result <= '0;
            r_flags  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bf16_addsub.sv
// Directed-vector bench for bf16_addsub with a real-arithmetic reference model and scoreboard.
// Latency: checks valid_o timing against the model's expected latency.
// Backpressure: exercises ready_i hold in DONE and a mid-operation reset.
module tb_bf16_addsub;

  logic        clk_i = 1'b0;
  logic        rst_i, valid_i, ready_o, op_i, valid_o, ready_i;
  logic [15:0] a_i, b_i, result_o;
  logic [3:0]  flags_o;

  always #5 clk_i = ~clk_i;

  bf16_addsub dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o),
    .flags_o  (flags_o)
  );

  typedef struct {
    logic [15:0] res;
    logic [3:0]  fl;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic prev_vld = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic real pow2(input int n);
    real r;
    r = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
    else        for (int i = 0; i < -n; i++) r = r / 2.0;
    return r;
  endfunction

  // Reference: exact sum in real arithmetic, then RNE to bf16 with range checks.
  function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic op,
                                output logic [15:0] res, output logic [3:0] fl, output int lat);
    logic sa, sbe, neg;
    int   ea, eb, ma, mb, e, m, big_e, k, bexp;
    real  va, vb, s, mag, scaled, frac;
    sa = a[15]; sbe = b[15] ^ op;
    ea = int'(a[14:7]); ma = int'(a[6:0]);
    eb = int'(b[14:7]); mb = int'(b[6:0]);
    res = 16'h0000; fl = 4'h0; lat = 4;
    if ((ea == 255 && ma != 0) || (eb == 255 && mb != 0)) begin
      res = 16'h7FC0; lat = 1;
    end else if (ea == 255 && eb == 255) begin
      lat = 1;
      if (sa != sbe) begin res = 16'h7FC0; fl = 4'b1000; end
      else res = {sa, 15'h7F80};
    end else if (ea == 255) begin
      lat = 1; res = {sa, 15'h7F80};
    end else if (eb == 255) begin
      lat = 1; res = {sbe, 15'h7F80};
    end else if (ea == 0 && eb == 0) begin
      res = {sa & sbe, 15'h0000};
    end else begin
      va = (ea == 0) ? 0.0 : (128 + ma) * pow2(ea - 134);
      vb = (eb == 0) ? 0.0 : (128 + mb) * pow2(eb - 134);
      if (sa)  va = -va;
      if (sbe) vb = -vb;
      s = va + vb;
      if (s != 0.0) begin
        neg = (s < 0.0);
        mag = neg ? -s : s;
        big_e = -200;
        if (ea != 0) big_e = ea - 127;
        if (eb != 0 && (eb - 127) > big_e) big_e = eb - 127;
        e = big_e + 1;
        while (mag < pow2(e)) e--;
        k = big_e - e;
        if (k < 0) k = 0;
        lat = 4 + k;
        scaled = mag / pow2(e - 7);
        m = $rtoi(scaled);
        frac = scaled - m;
        fl[0] = (frac != 0.0);
        if (frac > 0.5 || (frac == 0.5 && (m % 2) == 1)) m++;
        if (m == 256) begin m = 128; e++; end
        bexp = e + 127;
        if (bexp >= 255) begin res = {neg, 15'h7F80}; fl = 4'b0101; end
        else if (bexp <= 0) begin res = {neg, 15'h0000}; fl = 4'b0011; end
        else res = {neg, bexp[7:0], m[6:0]};
      end
    end
  endfunction

  // Compare process: every cycle valid_o is up, DUT output must match the scoreboard head.
  always @(negedge clk_i) begin
    if (!rst_i && valid_o) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 32'(valid_o), 32'd0);
      end else begin
        check("result", 32'(result_o), 32'(sb[0].res));
        check("flags", 32'(flags_o), 32'(sb[0].fl));
        check("ready_o_in_done", 32'(ready_o), 32'd0);
        if (!prev_vld) check("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
        if (ready_i) void'(sb.pop_front());
      end
    end
    prev_vld <= valid_o;
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic op,
                       input logic [15:0] lit_res, input logic [3:0] lit_fl, input int lit_lat);
    logic [15:0] mres;
    logic [3:0]  mfl;
    int          mlat, t;
    model(a, b, op, mres, mfl, mlat);
    check("model_res", 32'(mres), 32'(lit_res));
    check("model_flags", 32'(mfl), 32'(lit_fl));
    check("model_lat", 32'(mlat), 32'(lit_lat));
    t = 0;
    while (!ready_o && t < 50) begin @(posedge clk_i); #2; t++; end
    if (!ready_o) check("ready_timeout", 32'(ready_o), 32'd1);
    valid_i = 1'b1; a_i = a; b_i = b; op_i = op;
    sb.push_back('{res: mres, fl: mfl, lat: mlat, acc: cyc + 1});
    @(posedge clk_i); #2;
    valid_i = 1'b0; a_i = 16'($urandom); b_i = 16'($urandom); op_i = 1'($urandom);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 100) begin @(posedge clk_i); #2; t++; end
    if (sb.size() != 0) begin
      check("done_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic run(input logic [15:0] a, input logic [15:0] b, input logic op,
                     input logic [15:0] lit_res, input logic [3:0] lit_fl, input int lit_lat);
    issue(a, b, op, lit_res, lit_fl, lit_lat);
    wait_done();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; op_i = 1'b0; a_i = '0; b_i = '0;
    repeat (3) @(posedge clk_i);
    #2;
    check("rst_ready_o", 32'(ready_o), 32'd1);
    check("rst_valid_o", 32'(valid_o), 32'd0);
    check("rst_result_o", 32'(result_o), 32'h0);
    check("rst_flags_o", 32'(flags_o), 32'h0);
    rst_i = 1'b0;
    @(posedge clk_i); #2;

    //   a        b        op    result   {nv,of,uf,nx} latency
    run(16'h3F80, 16'h3F80, 1'b0, 16'h4000, 4'b0000, 4);
    run(16'h3F80, 16'h3F7F, 1'b1, 16'h3B80, 4'b0000, 12);
    run(16'h3F80, 16'h3B80, 1'b0, 16'h3F80, 4'b0001, 4);
    run(16'h3F81, 16'h3B80, 1'b0, 16'h3F82, 4'b0001, 4);
    run(16'h3F80, 16'h3F80, 1'b1, 16'h0000, 4'b0000, 4);
    run(16'h7F7F, 16'h7F7F, 1'b0, 16'h7F80, 4'b0101, 4);
    run(16'h7F80, 16'hFF80, 1'b0, 16'h7FC0, 4'b1000, 1);
    run(16'h7FC1, 16'h3F80, 1'b0, 16'h7FC0, 4'b0000, 1);
    run(16'h8000, 16'h8000, 1'b0, 16'h8000, 4'b0000, 4);
    run(16'h8000, 16'h0000, 1'b1, 16'h8000, 4'b0000, 4);
    run(16'h4040, 16'h0000, 1'b0, 16'h4040, 4'b0000, 4);
    run(16'h7F80, 16'h3F80, 1'b1, 16'h7F80, 4'b0000, 1);
    run(16'h3F80, 16'hFF80, 1'b0, 16'hFF80, 4'b0000, 1);
    run(16'hC000, 16'h3F80, 1'b0, 16'hBF80, 4'b0000, 5);
    run(16'h0080, 16'h0081, 1'b1, 16'h8000, 4'b0011, 11);
    run(16'h3F80, 16'h3A80, 1'b0, 16'h3F80, 4'b0001, 4);
    run(16'h4580, 16'h3F80, 1'b0, 16'h4580, 4'b0001, 4);

    // Consumer stall in DONE: result must hold and stray valid_i pulses must be ignored.
    ready_i = 1'b0;
    issue(16'h4000, 16'h4000, 1'b0, 16'h4080, 4'b0000, 4);
    t = 0;
    while (!valid_o && t < 20) begin @(posedge clk_i); #2; t++; end
    check("hold_reached_done", 32'(valid_o), 32'd1);
    repeat (5) begin
      valid_i = ~valid_i; a_i = 16'h3F80; b_i = 16'h3F80; op_i = 1'b0;
      @(posedge clk_i); #2;
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    wait_done();
    repeat (8) @(posedge clk_i);
    #2;
    check("hold_idle_ready", 32'(ready_o), 32'd1);

    // Reset while normalising: operation dropped, no result ever appears.
    issue(16'h3F80, 16'h3F7F, 1'b1, 16'h3B80, 4'b0000, 12);
    repeat (4) begin @(posedge clk_i); #2; end
    rst_i = 1'b1;
    @(posedge clk_i); #2;
    rst_i = 1'b0;
    sb.delete();
    check("midrst_ready_o", 32'(ready_o), 32'd1);
    check("midrst_valid_o", 32'(valid_o), 32'd0);
    check("midrst_result_o", 32'(result_o), 32'h0);
    check("midrst_flags_o", 32'(flags_o), 32'h0);
    repeat (15) @(posedge clk_i);
    #2;

    // Unit still works after the reset.
    run(16'h3F80, 16'h3F80, 1'b0, 16'h4000, 4'b0000, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
